// File: rtl/xlr8_tone_gen.sv
// xlr8_tone_gen: NUM_CH-channel square-wave tone generator on the AVR data-memory register bus.
// Optional macro TONE_BURST_EN adds per-channel BURST registers for counted toggle bursts.
module xlr8_tone_gen #(
    parameter int BASE_ADDR = 0,
    parameter int NUM_CH    = 2,
    parameter int PRESCALE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [7:0]        dbus_in,
    output logic [7:0]        dbus_out,
    output logic              io_out_en,
    input  logic [7:0]        ramadr,
    input  logic              ramre,
    input  logic              ramwe,
    input  logic              dm_sel,
    output logic [NUM_CH-1:0] tone_out
);
`ifdef TONE_BURST_EN
    localparam int WIN = 2 + 3*NUM_CH;
`else
    localparam int WIN = 2 + 2*NUM_CH;
`endif
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [8:0]        off9;
    logic [7:0]        off;
    logic              sel, wr, wr_ctrl, tick, gen, gen_nx;
    logic [NUM_CH-1:0] cen, cen_nx, act_now, act_nx, tgl, wr_lo, wr_hi, burst_done;
    logic [7:0]        stage, rdata;
    logic [15:0]       div    [NUM_CH];
    logic [15:0]       div_nx [NUM_CH];
    logic [15:0]       cnt    [NUM_CH];
    logic [PW-1:0]     pcnt;

    // 9-bit offset: addresses below BASE_ADDR wrap to >= 256 and fall outside the window
    assign off9      = {1'b0, ramadr} - 9'(BASE_ADDR);
    assign off       = off9[7:0];
    assign sel       = dm_sel && (off9 < 9'(WIN));
    assign wr        = sel && ramwe && clken;
    assign io_out_en = sel && ramre;
    assign dbus_out  = io_out_en ? rdata : 8'd0;
    assign tick      = (pcnt == PW'(PRESCALE - 1));

    // Post-edge register values decide activity, so a disabling write beats a same-edge toggle.
    always_comb begin
        wr_ctrl = wr && (off == 8'd0);
        gen_nx  = wr_ctrl ? dbus_in[7] : gen;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_lo[i]   = wr && (off == 8'(2 + 2*i));
            wr_hi[i]   = wr && (off == 8'(3 + 2*i));
            cen_nx[i]  = wr_ctrl ? dbus_in[i] : (cen[i] && !burst_done[i]);
            div_nx[i]  = wr_hi[i] ? {dbus_in, stage} : div[i];
            act_now[i] = gen && cen[i] && (div[i] != 16'd0);
            act_nx[i]  = gen_nx && cen_nx[i] && (div_nx[i] != 16'd0);
            tgl[i]     = act_now[i] && act_nx[i] && !wr_hi[i] && tick && (cnt[i] == div[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen      <= 1'b0;
            cen      <= '0;
            stage    <= 8'd0;
            pcnt     <= '0;
            tone_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i] <= 16'd0;
                cnt[i] <= 16'd0;
            end
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            gen  <= gen_nx;
            cen  <= cen_nx;
            if (|wr_lo)
                stage <= dbus_in;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i] <= div_nx[i];
                if (!act_nx[i]) begin
                    cnt[i]      <= 16'd0;
                    tone_out[i] <= 1'b0;
                end else if (wr_hi[i] || !act_now[i]) begin
                    // fresh enable or divider commit: restart the half-period, keep the level
                    cnt[i] <= 16'd0;
                end else if (tick) begin
                    if (tgl[i]) begin
                        cnt[i]      <= 16'd0;
                        tone_out[i] <= ~tone_out[i];
                    end else begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end
            end
        end
    end

`ifdef TONE_BURST_EN
    logic [7:0]        burst [NUM_CH];
    logic [7:0]        rem   [NUM_CH];
    logic [NUM_CH-1:0] wr_burst, cen_rise;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_burst[i] = wr && (off == 8'(2 + 2*NUM_CH + i));
            cen_rise[i] = wr_ctrl && dbus_in[i] && (!cen[i] || burst_done[i]);
        end
    end

    // burst_done pulses for one cycle after the final toggle; it clears CEN on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_done <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                burst[i] <= 8'd0;
                rem[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                burst_done[i] <= 1'b0;
                if (wr_burst[i]) begin
                    burst[i] <= dbus_in;
                    rem[i]   <= dbus_in;
                end else if (cen_rise[i]) begin
                    rem[i] <= burst[i];
                end else if (tgl[i] && (burst[i] != 8'd0) && (rem[i] != 8'd0)) begin
                    rem[i]        <= rem[i] - 8'd1;
                    burst_done[i] <= (rem[i] == 8'd1);
                end
            end
        end
    end
`else
    assign burst_done = '0;
`endif

    always_comb begin
        rdata = 8'd0;
        if (off == 8'd0)
            rdata = {gen, 7'(cen)};
        else if (off == 8'd1)
            rdata = 8'(tone_out);
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == 8'(2 + 2*i))
                rdata = div[i][7:0];
            if (off == 8'(3 + 2*i))
                rdata = div[i][15:8];
`ifdef TONE_BURST_EN
            if (off == 8'(2 + 2*NUM_CH + i))
                rdata = burst[i];
`endif
        end
    end

endmodule

// File: tb/tb_xlr8_tone_gen.sv
// tb_xlr8_tone_gen: register-table, directed and randomized checks of xlr8_tone_gen
// using two instances (PRESCALE=1 at 0x20, PRESCALE=4 at 0x40) on one shared bus.
`timescale 1ns/1ps
module tb_xlr8_tone_gen;
    localparam int B1 = 'h20;
    localparam int B4 = 'h40;
`ifdef TONE_BURST_EN
    localparam int WIN = 8;
`else
    localparam int WIN = 6;
`endif

    logic       clk = 1'b0, rst = 1'b0, clken = 1'b0;
    logic       ramre = 1'b0, ramwe = 1'b0, dm_sel = 1'b0;
    logic [7:0] dbus_in = 8'd0, ramadr = 8'd0;
    logic [7:0] dout_a, dout_b;
    logic       io_a, io_b;
    logic [1:0] tone_a, tone_b;

    int errors = 0, checks = 0;
    int ecount = 0;
    int last_wr = 0;
    // model per [instance][channel]: active flag, segment start edge, level at start, divider
    int m_act[2][2], m_start[2][2], m_l0[2][2], m_d[2][2];
    int e0, tgt, k, lvl_before, t1, t2, prev, mask, nd, ch;
    int dsel[2][2];

    typedef struct {
        logic       wr;
        logic       ce;
        logic       dm;
        logic [7:0] addr;
        logic [7:0] data;
        logic       io;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    xlr8_tone_gen #(.BASE_ADDR(B1), .NUM_CH(2), .PRESCALE(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dout_a),
        .io_out_en(io_a), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_sel(dm_sel), .tone_out(tone_a));

    xlr8_tone_gen #(.BASE_ADDR(B4), .NUM_CH(2), .PRESCALE(4)) u_dut_p4 (
        .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dout_b),
        .io_out_en(io_b), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_sel(dm_sel), .tone_out(tone_b));

    // index of the next active edge since reset release
    always @(posedge clk or posedge rst)
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Level = start level flipped once per (d+1) prescaler ticks since the segment start edge.
    function automatic int exp_lvl(input int dut, input int c, input int last);
        int p, t;
        if (m_act[dut][c] == 0) return 0;
        p = (dut == 0) ? 1 : 4;
        if (last < m_start[dut][c]) t = 0;
        else t = (last + 1) / p - (m_start[dut][c] + 1) / p;
        return m_l0[dut][c] ^ ((t / (m_d[dut][c] + 1)) % 2);
    endfunction

    task automatic m_enable(input int dut, input int c, input int d, input int edge_i);
        m_act[dut][c]   = (d != 0) ? 1 : 0;
        m_start[dut][c] = edge_i;
        m_l0[dut][c]    = 0;
        m_d[dut][c]     = d;
    endtask

    task automatic m_commit(input int dut, input int c, input int d, input int edge_i);
        m_l0[dut][c]    = exp_lvl(dut, c, edge_i - 1);
        m_act[dut][c]   = (d != 0) ? m_act[dut][c] : 0;
        m_start[dut][c] = edge_i;
        m_d[dut][c]     = d;
    endtask

    task automatic m_clear();
        for (int a = 0; a < 2; a++)
            for (int c = 0; c < 2; c++) m_act[a][c] = 0;
    endtask

    task automatic check_tones(input string name);
        int last, got;
        last = ecount - 1;
        for (int a = 0; a < 2; a++)
            for (int c = 0; c < 2; c++) begin
                got = (a == 0) ? int'(tone_a[c]) : int'(tone_b[c]);
                chk($sformatf("%s tone u%0d ch%0d edge%0d", name, a, c, last), got, exp_lvl(a, c, last));
            end
    endtask

    task automatic run_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_tones(name);
        end
    endtask

    // caller must be between clock edges; the write lands on the next rising edge
    task automatic bus_wr(input logic [7:0] addr, input logic [7:0] data, input logic ce);
        last_wr = ecount;
        ramadr  = addr;
        dbus_in = data;
        dm_sel  = 1'b1;
        ramwe   = 1'b1;
        clken   = ce;
        @(posedge clk);
        #1;
        ramwe  = 1'b0;
        dm_sel = 1'b0;
        clken  = 1'b0;
    endtask

    task automatic bus_wr_at(input int target, input logic [7:0] addr, input logic [7:0] data);
        while (ecount < target) @(negedge clk);
        bus_wr(addr, data, 1'b1);
    endtask

    task automatic bus_rd(input string name, input logic [7:0] addr, input logic dm,
                          input logic [7:0] exp, input logic exp_io);
        logic [17:0] got_all, exp_all;
        @(negedge clk);
        ramadr = addr;
        dm_sel = dm;
        ramre  = 1'b1;
        #1;
        got_all = {io_b, dout_b, io_a, dout_a};
        exp_all = (addr >= 8'(B4)) ? {exp_io, exp, 9'd0} : {9'd0, exp_io, exp};
        chk(name, int'(got_all), int'(exp_all));
        ramre  = 1'b0;
        dm_sel = 1'b0;
    endtask

    task automatic prog_div(input int dut, input int c, input int d);
        logic [7:0] base;
        base = (dut == 0) ? 8'(B1) : 8'(B4);
        bus_wr(base + 8'(2 + 2*c), 8'(d), 1'b1);
        bus_wr(base + 8'(3 + 2*c), 8'(d >> 8), 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // register map table: wr, clken, dm_sel, addr, data (write data or expected read), io
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 8'h00, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h25, 8'h00, 1'b1});
        vt.push_back('{1'b1, 1'b1, 1'b1, 8'h20, 8'hFF, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h20, 8'h83, 1'b1});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h20, 8'h83, 1'b1});
        vt.push_back('{1'b1, 1'b1, 1'b1, 8'h20, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1});
        vt.push_back('{1'b1, 1'b1, 1'b1, 8'h22, 8'h34, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 8'h00, 1'b1});
        vt.push_back('{1'b1, 1'b1, 1'b1, 8'h23, 8'h12, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 8'h34, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h23, 8'h12, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h1F, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'(B1 + WIN), 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0});
        vt.push_back('{1'b1, 1'b1, 1'b1, 8'h21, 8'hAA, 1'b0});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h40, 8'h00, 1'b1});
        foreach (vt[i]) begin
            if (vt[i].wr) begin
                @(negedge clk);
                bus_wr(vt[i].addr, vt[i].data, vt[i].ce);
            end else begin
                bus_rd($sformatf("vec%0d rd 0x%0h", i, vt[i].addr), vt[i].addr, vt[i].dm,
                       vt[i].data, vt[i].io);
            end
        end

        // basic tone with STATUS held on the bus
        @(negedge clk);
        prog_div(0, 0, 3);
        bus_wr(8'(B1), 8'h81, 1'b1);
        m_enable(0, 0, 3, last_wr);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ramadr = 8'(B1 + 1);
            dm_sel = 1'b1;
            ramre  = 1'b1;
            #1;
            check_tones("basic");
            chk("status", int'(dout_a), exp_lvl(0, 0, ecount - 1) | (exp_lvl(0, 1, ecount - 1) << 1));
        end
        ramre  = 1'b0;
        dm_sel = 1'b0;

        // low byte alone must not change the period; the high byte commits on a toggle edge
        bus_wr(8'(B1 + 2), 8'h10, 1'b1);
        run_check(6, "atomic_lo");
        e0  = m_start[0][0];
        k   = (ecount + 1 - e0 + 3) / 4;
        tgt = e0 + 4 * k;
        bus_wr_at(tgt, 8'(B1 + 3), 8'h00);
        lvl_before = exp_lvl(0, 0, last_wr - 1);
        m_commit(0, 0, 16'h0010, last_wr);
        @(negedge clk);
        chk("commit_no_glitch", int'(tone_a[0]), lvl_before);
        run_check(40, "atomic_hi");

        // gating: two channels, then GEN off on an edge where ch0 would rise
        bus_wr(8'(B1), 8'h00, 1'b1);
        m_clear();
        prog_div(0, 0, 3);
        prog_div(0, 1, 5);
        bus_wr(8'(B1), 8'h83, 1'b1);
        m_enable(0, 0, 3, last_wr);
        m_enable(0, 1, 5, last_wr);
        run_check(10, "gate_run");
        e0 = m_start[0][0];
        k  = (ecount + 1 - e0 + 3) / 4;
        if (k % 2 == 0) k++;
        bus_wr_at(e0 + 4 * k, 8'(B1), 8'h01);
        m_clear();
        @(negedge clk);
        chk("gate_same_edge", int'(tone_a), 0);
        run_check(5, "gate_off");
        prog_div(0, 1, 0);
        bus_wr(8'(B1), 8'h83, 1'b1);
        m_enable(0, 0, 3, last_wr);
        m_enable(0, 1, 0, last_wr);
        run_check(20, "div_zero");

        // prescale 4: DIV=2 gives a 12-clock half-period
        bus_wr(8'(B4), 8'h00, 1'b1);
        prog_div(1, 0, 2);
        bus_wr(8'(B4), 8'h81, 1'b1);
        m_enable(1, 0, 2, last_wr);
        prev = 0; t1 = -1; t2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check_tones("p4");
            if (int'(tone_b[0]) != prev) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
                prev = int'(tone_b[0]);
            end
        end
        chk("p4_half_period", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, 12);
        bus_wr(8'(B4), 8'h00, 1'b0);
        bus_rd("p4_clken0_ctrl", 8'(B4), 1'b1, 8'h81, 1'b1);
        bus_wr(8'(B4 + 2), 8'h02, 1'b1);
        bus_wr(8'(B4 + 3), 8'hA5, 1'b1);
        m_commit(1, 0, 16'hA502, last_wr);
        bus_rd("p4_divhi_read", 8'(B4 + 3), 1'b1, 8'hA5, 1'b1);

        // asynchronous reset while ch0 is high
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tone_a[0]) break;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tone", int'({tone_b, tone_a}), 0);
        m_clear();
        @(negedge clk);
        rst = 1'b0;
        bus_rd("rst_ctrl_a", 8'(B1), 1'b1, 8'h00, 1'b1);
        bus_rd("rst_ctrl_b", 8'(B4), 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        chk("idle_bus", int'({io_b, dout_b, io_a, dout_a}), 0);
        run_check(10, "post_rst");

        // randomized programming of both instances against the model
        for (int r = 0; r < 8; r++) begin
            bus_wr(8'(B1), 8'h00, 1'b1);
            bus_wr(8'(B4), 8'h00, 1'b1);
            m_clear();
            for (int a = 0; a < 2; a++)
                for (int c = 0; c < 2; c++) begin
                    dsel[a][c] = int'($urandom_range(0, 12));
                    prog_div(a, c, dsel[a][c]);
                end
            for (int a = 0; a < 2; a++) begin
                mask = int'($urandom_range(0, 3));
                bus_wr((a == 0) ? 8'(B1) : 8'(B4), 8'h80 | 8'(mask), 1'b1);
                for (int c = 0; c < 2; c++)
                    if (mask[c]) m_enable(a, c, dsel[a][c], last_wr);
                if (a == 0) dsel[0][0] = mask;
            end
            run_check(int'($urandom_range(20, 60)), $sformatf("rand%0d", r));
            ch = int'($urandom_range(0, 1));
            nd = int'($urandom_range(1, 12));
            prog_div(0, ch, nd);
            if (dsel[0][0][ch]) begin
                if (m_act[0][ch] != 0) m_commit(0, ch, nd, last_wr);
                else m_enable(0, ch, nd, last_wr);
            end
            run_check(int'($urandom_range(20, 60)), $sformatf("rand%0d_commit", r));
        end

`ifdef TONE_BURST_EN
        // burst of 3 toggles, then hardware clears CEN0
        bus_wr(8'(B1), 8'h00, 1'b1);
        m_clear();
        prog_div(0, 0, 1);
        bus_wr(8'(B1 + WIN - 2), 8'h03, 1'b1);
        bus_wr(8'(B1), 8'h81, 1'b1);
        begin
            int exp_seq[10] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk($sformatf("burst_seq%0d", i), int'(tone_a[0]), exp_seq[i]);
            end
        end
        bus_rd("burst_ctrl", 8'(B1), 1'b1, 8'h80, 1'b1);
        bus_rd("burst_reg", 8'(B1 + WIN - 2), 1'b1, 8'h03, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
